pconv_collector: RTL and testbench
==================================

// Module: pconv_collector
// PURPOSE
//  Write side of the partial-convolution bus consumed by conv. Accepts signed
//  PCONV_LEN-bit partial sums from the MAC core one per beat. It packs them
//  into the NUM_PCONV-slot o_pconv bus, with slot k at bits [PCONV_LEN*k +: PCONV_LEN].
//  It then presents the bus with its layer tag under a valid/ready handshake.
//  A fill stops at the last slot the layer needs: slot 52 for L0, 22 for L1, 6 for L2.
// PARAMETERS
//  PCONV_LEN  18  width of one signed partial sum
//  NUM_PCONV  53  number of slots on the packed bus
// PORTS
//  i_clk          in   1                    single clock, rising edge
//  i_rst_n        in   1                    asynchronous, active-low reset
//  i_start        in   1                    begin a new fill (1-cycle pulse)
//  i_layer_num    in   2                    layer for this fill, sampled on accepted i_start
//  i_pconv_valid  in   1                    i_pconv_data is valid
//  o_pconv_ready  out  1                    collector accepts a beat
//  i_pconv_data   in   PCONV_LEN            signed partial sum for the next slot
//  o_valid        out  1                    o_pconv / o_layer_num complete and stable
//  i_ready        in   1                    consumer takes the bus
//  o_pconv        out  PCONV_LEN*NUM_PCONV  packed slots, slot 0 in the LSBs
//  o_layer_num    out  2                    layer tag of the held bus (feeds conv layer_num)
//  o_busy         out  1                    high in FILL or HOLD
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, slot index=0, o_pconv=0, o_layer_num=0.
//    All outputs are 0 while i_rst_n=0.
//  - Last slot: LAST = 52 for layer 0, 22 for layer 1, 6 for layer 2.
//    Layer 3 is coerced to 0 at capture: LAST=52, o_layer_num=0.
//  - IDLE: o_pconv_ready=0, o_valid=0.
//    i_start=1 moves to FILL next cycle, latches the layer, sets index=0
//    and clears o_pconv to 0.
//  - FILL: o_pconv_ready=1, registered, and high the cycle after entry.
//    A beat is accepted when i_pconv_valid & o_pconv_ready.
//    Each accepted beat writes i_pconv_data unchanged (no extension) into slot[index], then index+1.
//    i_pconv_valid=0 stalls with no state change.
//    The beat written to slot LAST moves to HOLD next cycle; o_pconv_ready drops in that same next cycle.
//    Slots above LAST stay 0.
//  - HOLD: o_valid=1, o_pconv_ready=0; o_pconv and o_layer_num are frozen.
//    o_valid stays high until i_ready=1, then clears.
//    i_ready=1 with i_start=0 goes to IDLE.
//    i_ready=1 with i_start=1 in the same cycle goes straight to FILL:
//    new layer latched, bus cleared, no idle bubble.
//  - i_start while in FILL, or in HOLD without i_ready, is ignored.
//  - Latency: last beat accepted in cycle N gives o_valid=1 in cycle N+1, all outputs registered.
//  - Minimum fill: LAST+1 accepted beats, i.e. 53, 23 or 7.
//  - Index never exceeds LAST and never wraps; no beat is accepted outside FILL.
//  - Reset mid-fill or mid-hold discards all data; no partial bus is ever flagged valid.
//  - o_busy = (state != IDLE).
// TESTING
//  - Reset check: hold i_rst_n=0 mid-FILL, then release.
//    -> o_valid=0, o_pconv=0, o_pconv_ready=0; next start refills from slot 0.
//  - Layer 2, beats 1..7 back-to-back:
//    -> o_valid on the cycle after beat 7; slots 0..6 = 1..7, slots 7..52 = 0, o_layer_num=2.
//  - Layer 0 with slots 0/26/52 = 0x1FFFF/0x3FFFF/0x00005 and all other beats 0, i_ready=1:
//    -> the bus matches exactly; through conv, o_conv = 0x020003.
//  - Layer 1, i_pconv_valid toggling every other cycle, i_ready held low 5 cycles:
//    -> exactly 23 beats accepted; bus frozen and o_valid high for all 5 cycles; IDLE after i_ready.
//  - HOLD with i_ready and i_start=1 (layer 3) in the same cycle:
//    -> next cycle FILL, bus=0, o_layer_num=0, 53 beats expected.
//  - i_start pulsed mid-FILL, and i_pconv_valid held high in IDLE/HOLD:
//    -> no restart, no extra slot writes.

Source files
------------

// File: rtl/pconv_collector.sv
//==============================================================================
// Module      : pconv_collector
// Description : Packs signed partial sums, one per beat, into the slotted
//               partial-convolution bus and hands it off under valid/ready.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pconv_collector #(
  parameter int PCONV_LEN = 18,
  parameter int NUM_PCONV = 53
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [1:0]                     i_layer_num,
  input  logic                           i_pconv_valid,
  output logic                           o_pconv_ready,
  input  logic [PCONV_LEN-1:0]           i_pconv_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [PCONV_LEN*NUM_PCONV-1:0] o_pconv,
  output logic [1:0]                     o_layer_num,
  output logic                           o_busy
);

  localparam int IDX_W = $clog2(NUM_PCONV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_slot;
  logic [1:0]       layer_cap;
  logic             take_start;
  logic             beat;

  // Layer 3 is not a real layer; it is treated as layer 0 from capture onward.
  assign layer_cap  = (i_layer_num == 2'd3) ? 2'd0 : i_layer_num;
  assign take_start = i_start && ((state == ST_IDLE) || ((state == ST_HOLD) && i_ready));
  assign beat       = (state == ST_FILL) && i_pconv_valid && o_pconv_ready;

  function automatic logic [IDX_W-1:0] last_of(input logic [1:0] layer);
    logic [IDX_W-1:0] last;
    case (layer)
      2'd1:    last = IDX_W'(22);
      2'd2:    last = IDX_W'(6);
      default: last = IDX_W'(NUM_PCONV - 1);
    endcase
    return last;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      last_slot     <= '0;
      o_pconv       <= '0;
      o_layer_num   <= 2'd0;
      o_pconv_ready <= 1'b0;
      o_valid       <= 1'b0;
      o_busy        <= 1'b0;
    end else if (take_start) begin
      // Covers both IDLE and the back-to-back handoff out of HOLD.
      state         <= ST_FILL;
      idx           <= '0;
      last_slot     <= last_of(layer_cap);
      o_pconv       <= '0;
      o_layer_num   <= layer_cap;
      o_pconv_ready <= 1'b1;
      o_valid       <= 1'b0;
      o_busy        <= 1'b1;
    end else begin
      case (state)
        ST_FILL: begin
          if (beat) begin
            o_pconv[PCONV_LEN*int'(idx) +: PCONV_LEN] <= i_pconv_data;
            if (idx == last_slot) begin
              state         <= ST_HOLD;
              o_pconv_ready <= 1'b0;
              o_valid       <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          o_pconv_ready <= 1'b0;
          o_valid       <= 1'b0;
          o_busy        <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          o_pconv_ready <= 1'b0;
          o_valid       <= 1'b0;
          o_busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pconv_collector.sv
//==============================================================================
// Module      : tb_pconv_collector
// Description : Randomized and directed bench for pconv_collector against a
//               transaction-level model (beat queue per fill).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pconv_collector;

  localparam int PL = 18;
  localparam int NP = 53;
  localparam int BW = PL * NP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    layer = 2'd0;
  logic          pvalid = 1'b0;
  logic          pready;
  logic [PL-1:0] pdata = '0;
  logic          valid;
  logic          rdy = 1'b0;
  logic [BW-1:0] pconv;
  logic [1:0]    layer_out;
  logic          busy;

  pconv_collector #(.PCONV_LEN(PL), .NUM_PCONV(NP)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_layer_num   (layer),
    .i_pconv_valid (pvalid),
    .o_pconv_ready (pready),
    .i_pconv_data  (pdata),
    .o_valid       (valid),
    .i_ready       (rdy),
    .o_pconv       (pconv),
    .o_layer_num   (layer_out),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 presenting.
  int            m_phase = 0;
  logic [1:0]    m_layer = 2'd0;
  int            m_need  = NP;
  logic [PL-1:0] m_beats[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int need_of(input logic [1:0] l);
    if (l == 2'd1) return 23;
    if (l == 2'd2) return 7;
    return 53;
  endfunction

  function automatic logic [PL-1:0] exp_slot(input int k);
    if (k < m_beats.size()) return m_beats[k];
    return '0;
  endfunction

  task automatic check_outputs();
    check("ready", 64'(pready), 64'(m_phase == 1));
    check("valid", 64'(valid), 64'(m_phase == 2));
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("layer", 64'(layer_out), 64'(m_layer));
    for (int k = 0; k < NP; k++)
      check($sformatf("slot%0d", k), 64'(pconv[k*PL +: PL]), 64'(exp_slot(k)));
  endtask

  task automatic model_edge();
    if (start && (m_phase == 0 || (m_phase == 2 && rdy))) begin
      m_phase = 1;
      m_layer = (layer == 2'd3) ? 2'd0 : layer;
      m_need  = need_of(layer);
      m_beats.delete();
    end else if (m_phase == 1 && pvalid) begin
      m_beats.push_back(pdata);
      if (m_beats.size() == m_need) m_phase = 2;
    end else if (m_phase == 2 && rdy) begin
      m_phase = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (pready && pvalid) accepts++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit s, input logic [1:0] l, input bit pv,
                       input logic [PL-1:0] d, input bit r);
    start = s; layer = l; pvalid = pv; pdata = d; rdy = r;
    step();
  endtask

  task automatic do_reset();
    start = 1'b0; pvalid = 1'b0; rdy = 1'b0;
    rst_n = 1'b0;
    m_phase = 0; m_layer = 2'd0; m_beats.delete();
    #2;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_ready", 64'(pready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bus_nz", 64'(|pconv), 64'd0);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Layer 2, beats 1..7 back-to-back, consumer stalls briefly
    drive(1, 2'd2, 0, '0, 0);
    for (int v = 1; v <= 7; v++) drive(0, 2'd0, 1, PL'(v), 0);
    check("l2_valid", 64'(valid), 64'd1);
    check("l2_slot6", 64'(pconv[6*PL +: PL]), 64'd7);
    check("l2_slot7", 64'(pconv[7*PL +: PL]), 64'd0);
    check("l2_tag", 64'(layer_out), 64'd2);
    drive(0, 2'd0, 1, PL'(99), 0);
    drive(0, 2'd0, 0, '0, 1);
    drive(0, 2'd0, 0, '0, 0);

    // Layer 0 directed corner values, consumer always ready
    drive(1, 2'd0, 0, '0, 1);
    for (int i = 0; i < NP; i++)
      drive(0, 2'd0, 1, (i == 0) ? 18'h1FFFF : (i == 26) ? 18'h3FFFF : (i == 52) ? 18'h00005 : 18'h0, 1);
    check("l0_slot0", 64'(pconv[0 +: PL]), 64'h1FFFF);
    check("l0_slot26", 64'(pconv[26*PL +: PL]), 64'h3FFFF);
    check("l0_slot52", 64'(pconv[52*PL +: PL]), 64'h5);
    drive(0, 2'd0, 0, '0, 1);

    // Layer 1, valid toggling, consumer stalls 5 cycles
    accepts = 0;
    drive(1, 2'd1, 0, '0, 0);
    for (int i = 0; i < 200 && m_phase == 1; i++) drive(0, 2'd0, i[0], PL'($urandom), 0);
    for (int i = 0; i < 5; i++) drive(0, 2'd0, 0, '0, 0);
    check("l1_accepts", 64'(accepts), 64'd23);
    drive(0, 2'd0, 0, '0, 1);
    drive(0, 2'd0, 0, '0, 0);
    check("l1_idle_busy", 64'(busy), 64'd0);

    // HOLD + start (layer 3) handoff, mid-fill start, valid held in HOLD/IDLE
    drive(1, 2'd2, 0, '0, 0);
    for (int i = 0; i < 7; i++) drive(0, 2'd0, 1, PL'($urandom), 0);
    drive(1, 2'd3, 1, PL'(5), 1);
    check("h2f_busy", 64'(busy), 64'd1);
    check("h2f_ready", 64'(pready), 64'd1);
    check("h2f_tag", 64'(layer_out), 64'd0);
    check("h2f_bus_nz", 64'(|pconv), 64'd0);
    accepts = 0;
    for (int i = 0; i < 53; i++) drive((i == 10) || (i == 30), 2'd1, 1, PL'($urandom), 0);
    check("l3_accepts", 64'(accepts), 64'd53);
    check("l3_valid", 64'(valid), 64'd1);
    for (int i = 0; i < 3; i++) drive(0, 2'd0, 1, PL'($urandom), 0);
    drive(0, 2'd0, 1, '0, 1);
    for (int i = 0; i < 3; i++) drive(0, 2'd0, 1, PL'($urandom), 0);

    // Reset mid-fill discards everything
    drive(1, 2'd0, 0, '0, 0);
    for (int i = 0; i < 20; i++) drive(0, 2'd0, 1, PL'($urandom), 0);
    do_reset();
    check("rstf_valid", 64'(valid), 64'd0);
    drive(1, 2'd2, 0, '0, 0);
    for (int i = 0; i < 7; i++) drive(0, 2'd0, 1, PL'(i + 40), 0);
    check("refill_slot0", 64'(pconv[0 +: PL]), 64'd40);
    drive(0, 2'd0, 0, '0, 1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++)
      drive(($urandom_range(0, 7) == 0), 2'($urandom), ($urandom_range(0, 3) != 0),
            PL'($urandom), ($urandom_range(0, 1) == 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
